cdc_handshake_tx: RTL and testbench

- Source-side initiator of a 2-phase (toggle) req/ack handshake that moves a multi-bit word out of the clkb domain into another clock domain.
- Captures a word on a valid/ready interface and holds it stable on xfer_data while toggling xfer_req.
- Waits for the far-side receiver to return a matching ack toggle, which arrives asynchronously and is synchronized internally.
- Used for video timing register updates (h/v totals, sync widths) crossing into the pixel clock domain.

---
 rtl/cdc_handshake_tx.sv | 140 ++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 2-phase (toggle) req/ack handshake.
// A word accepted on in_valid/in_ready is held on xfer_data while xfer_req
// toggles once; the far side returns an ack toggle on ack_async, which is
// synchronized into clkb before use.
// Optional build macro: CDC_TX_TIMEOUT_EN adds a sticky ack-overdue flag.
// SYNC_STAGES legal range is 2..4.
module cdc_handshake_tx #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clkb,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] xfer_data,
    output logic              xfer_req,
    input  logic              ack_async,
    output logic              done,
    output logic              proto_err,
    output logic              timeout_err
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;
    logic [DATA_W-1:0]       data_q;
    logic [DATA_W-1:0]       data_d;
    logic                    req_q;
    logic                    req_d;
    logic                    done_q;
    logic                    done_d;
    logic                    proto_q;
    logic                    proto_d;

    // Ack synchronizer chain; only the last stage feeds logic
    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // State and held-word registers
    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            proto_q <= proto_d;
        end
    end

    // Next state: accept in IDLE, wait for matching ack toggle in WAIT_ACK
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
        proto_d = proto_q;
        case (state_q)
            IDLE: begin
                // An ack edge with nothing outstanding is a protocol violation
                if (ack_s != req_q) begin
                    proto_d = 1'b1;
                end
                if (in_valid) begin
                    data_d  = in_data;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == req_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign xfer_data = data_q;
    assign xfer_req  = req_q;
    assign done      = done_q;
    assign proto_err = proto_q;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_err_q;

    // Count WAIT_ACK cycles; flag is set on the edge the count reaches the limit
    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d == WAIT_ACK)) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT_ACK) begin
            if (tmo_cnt_q != CNT_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_cnt_q >= (CNT_MAX - 1'b1)) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: two instances (SYNC_STAGES 2 and 3),
// ack either looped back from xfer_req or driven by the bench.
module tb_cdc_handshake_tx;

    localparam int unsigned DW  = 24;
    localparam int unsigned TMO = 8;
`ifdef CDC_TX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic          clkb = 1'b0;
    logic          rst_n;
    logic          in_valid    [2];
    logic [DW-1:0] in_data     [2];
    logic          in_ready    [2];
    logic [DW-1:0] xfer_data   [2];
    logic          xfer_req    [2];
    logic          ack_async   [2];
    logic          done        [2];
    logic          proto_err   [2];
    logic          timeout_err [2];
    logic          loop_en     [2];
    logic          ack_man     [2];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            done_cnt [2];
    int            exp_done [2];
    int            tog1;
    logic          prev_req1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign ack_async[g] = loop_en[g] ? xfer_req[g] : ack_man[g];

        cdc_handshake_tx #(
            .DATA_W     (DW),
            .SYNC_STAGES(2 + g),
            .TIMEOUT_CYC(TMO)
        ) u_dut (
            .clkb       (clkb),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_data    (in_data[g]),
            .in_ready   (in_ready[g]),
            .xfer_data  (xfer_data[g]),
            .xfer_req   (xfer_req[g]),
            .ack_async  (ack_async[g]),
            .done       (done[g]),
            .proto_err  (proto_err[g]),
            .timeout_err(timeout_err[g])
        );
    end

    always #5 clkb = ~clkb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkb);
        #1;
    endtask

    // Present one word for a single edge and record what the scoreboard should see
    task automatic send(input int idx, input logic [DW-1:0] d);
        check("send_rdy", 32'(in_ready[idx]), 32'd1);
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        tick();
        in_valid[idx] = 1'b0;
        if (idx == 0) q0.push_back(d);
        else          q1.push_back(d);
        exp_done[idx]++;
    endtask

    task automatic wait_done(input int idx, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done[idx]) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Scoreboard for instance 0: each done pulse retires the oldest accepted word
    always @(negedge clkb) begin
        if (rst_n && done[0]) begin
            done_cnt[0]++;
            if (q0.size() == 0) check("sb0_empty", 32'd0, 32'd1);
            else                check("sb0_data", 32'(xfer_data[0]), 32'(q0.pop_front()));
        end
    end

    // Scoreboard for instance 1, plus xfer_req toggle counting
    always @(negedge clkb) begin
        if (!rst_n) begin
            prev_req1 = 1'b0;
        end else begin
            if (xfer_req[1] != prev_req1) begin
                tog1++;
                prev_req1 = xfer_req[1];
            end
            if (done[1]) begin
                done_cnt[1]++;
                if (q1.size() == 0) check("sb1_empty", 32'd0, 32'd1);
                else                check("sb1_data", 32'(xfer_data[1]), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = '{1'b0, 1'b0};
        in_data   = '{24'd0, 24'd0};
        loop_en   = '{1'b1, 1'b1};
        ack_man   = '{1'b0, 1'b0};
        done_cnt  = '{0, 0};
        exp_done  = '{0, 0};
        tog1      = 0;
        prev_req1 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clkb);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(in_ready[i]), 32'd1);
            check("rst_req",   32'(xfer_req[i]), 32'd0);
            check("rst_data",  32'(xfer_data[i]), 32'd0);
            check("rst_done",  32'(done[i]), 32'd0);
            check("rst_perr",  32'(proto_err[i]), 32'd0);
            check("rst_tmo",   32'(timeout_err[i]), 32'd0);
        end

        // Single transfer, loopback, SYNC_STAGES=2: done in the cycle after edge k+3
        send(0, 24'hA5A5A5);
        check("lat_req",  32'(xfer_req[0]), 32'd1);
        check("lat_data", 32'(xfer_data[0]), 32'hA5A5A5);
        check("lat_busy", 32'(in_ready[0]), 32'd0);
        for (int j = 0; j < 2; j++) begin
            tick();
            check("lat_busy", 32'(in_ready[0]), 32'd0);
            check("lat_nodone", 32'(done[0]), 32'd0);
        end
        tick();
        check("lat_done", 32'(done[0]), 32'd1);
        check("lat_rdy",  32'(in_ready[0]), 32'd1);
        tick();
        check("lat_done_off", 32'(done[0]), 32'd0);

        // Continuous in_valid, loopback, SYNC_STAGES=3: one word per 5 cycles
        in_valid[1] = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            in_data[1] = DW'(w);
            tick();
            q1.push_back(DW'(w));
            exp_done[1]++;
            check("thr_data", 32'(xfer_data[1]), 32'(w));
            check("thr_req",  32'(xfer_req[1]), 32'(w % 2));
            in_data[1] = DW'(32'hBAD000 + w);
            for (int j = 0; j < 3; j++) begin
                tick();
                check("thr_busy", 32'(in_ready[1]), 32'd0);
            end
            tick();
            check("thr_done",     32'(done[1]), 32'd1);
            check("thr_rdy",      32'(in_ready[1]), 32'd1);
            check("thr_req_hold", 32'(xfer_req[1]), 32'(w % 2));
        end
        in_valid[1] = 1'b0;

        // Spurious ack toggles in IDLE set proto_err; transfers still work
        ack_man[0] = xfer_req[0];
        loop_en[0] = 1'b0;
        repeat (4) tick();
        check("perr_clear", 32'(proto_err[0]), 32'd0);
        ack_man[0] = ~ack_man[0];
        repeat (4) tick();
        check("perr_set", 32'(proto_err[0]), 32'd1);
        ack_man[0] = ~ack_man[0];
        repeat (4) tick();
        check("perr_sticky", 32'(proto_err[0]), 32'd1);
        loop_en[0] = 1'b1;
        send(0, 24'h123456);
        wait_done(0, 10, "perr_done");
        check("perr_after", 32'(proto_err[0]), 32'd1);

        // Reset pulse while in WAIT_ACK aborts the transfer
        ack_man[0] = xfer_req[0];
        loop_en[0] = 1'b0;
        send(0, 24'h654321);
        tick();
        check("abort_busy", 32'(in_ready[0]), 32'd0);
        rst_n      = 1'b0;
        ack_man[0] = 1'b0;
        #1;
        check("abort_req",  32'(xfer_req[0]), 32'd0);
        check("abort_data", 32'(xfer_data[0]), 32'd0);
        void'(q0.pop_back());
        exp_done[0]--;
        @(posedge clkb);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check("abort_nodone", 32'(done[0]), 32'd0);
        end
        check("abort_rdy",  32'(in_ready[0]), 32'd1);
        check("abort_perr", 32'(proto_err[0]), 32'd0);

        // Ack withheld: timeout_err after TMO cycles (feature builds only), wait continues
        send(0, 24'h0F0F0F);
        for (int j = 1; j < int'(TMO); j++) begin
            tick();
            check("tmo_early", 32'(timeout_err[0]), 32'd0);
        end
        tick();
        check("tmo_set", 32'(timeout_err[0]), 32'(TO_EN));
        repeat (3) tick();
        check("tmo_sticky", 32'(timeout_err[0]), 32'(TO_EN));
        check("tmo_waiting", 32'(in_ready[0]), 32'd0);
        ack_man[0] = 1'b1;
        wait_done(0, 10, "tmo_done");
        check("tmo_after", 32'(timeout_err[0]), 32'(TO_EN));

        // Final scoreboard reconciliation
        repeat (3) tick();
        check("done_cnt0", 32'(done_cnt[0]), 32'(exp_done[0]));
        check("done_cnt1", 32'(done_cnt[1]), 32'(exp_done[1]));
        check("done_cnt1_n", 32'(done_cnt[1]), 32'd4);
        check("toggles1", 32'(tog1), 32'd4);
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
